b_inpdt_mac: RTL and testbench

- Upstream neighbour of the B-path bias/quantize/sigmoid-scale stage.
- Streams VEC_LEN pairs of uint8 data (Xt/Ht) and uint8 weight. Removes each zero point and accumulates the signed products into a 32-bit inner product.
- Presents the result to the next stage with a fixed latency and a valid/ready handshake, together with the captured uint8 bias and the combinational-control code that selects B_BQS.

---
 rtl/b_inpdt_mac.sv | 118 +++++++++++
 tb/tb_b_inpdt_mac.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/b_inpdt_mac.sv
// Zero-point-corrected uint8 inner-product MAC for the B path.
// Hands the 32-bit result, captured bias and BQS control code to the next stage over valid/ready.
module b_inpdt_mac #(
  parameter int unsigned VEC_LEN   = 16,
  parameter int unsigned CNT_W     = 16,
  parameter logic [7:0]  ZERO_DATA = 8'd128,
  parameter logic [7:0]  ZERO_W    = 8'd128,
  parameter logic [4:0]  CTRL_BQS  = 5'd5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  bias_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  data_in,
  input  logic [7:0]  w_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] inpdt_R_reg,
  output logic [7:0]  bias_buffer,
  output logic [4:0]  comb_ctrl,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t              state, next_state;
  logic [CNT_W-1:0]    cnt;
  logic signed [31:0]  acc, acc_next;
  logic signed [8:0]   d_s, w_s;
  logic signed [17:0]  prod;
  logic                accept, last;
  logic                in_ready_d, out_valid_d, busy_d;
  logic [4:0]          comb_ctrl_d;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start)           next_state = ACC;
      ACC:     if (accept && last)  next_state = DONE;
      DONE:    if (out_ready)       next_state = IDLE;
      default:                      next_state = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the handshake outputs come straight from flops
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    comb_ctrl_d = 5'd0;
    case (next_state)
      ACC: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b1;
      end
      DONE: begin
        out_valid_d = 1'b1;
        busy_d      = 1'b1;
        comb_ctrl_d = CTRL_BQS;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      comb_ctrl <= 5'd0;
    end else begin
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
      comb_ctrl <= comb_ctrl_d;
    end
  end

  // Signed 9-bit operands after zero-point removal; 18-bit product sign-extended into the sum
  always_comb begin
    accept   = (state == ACC) && in_valid;
    last     = (cnt == CNT_W'(VEC_LEN - 1));
    d_s      = $signed({1'b0, data_in}) - $signed({1'b0, ZERO_DATA});
    w_s      = $signed({1'b0, w_in}) - $signed({1'b0, ZERO_W});
    prod     = d_s * w_s;
    acc_next = acc + 32'(prod);
  end

  // Accumulator, element counter and captured result/bias
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      cnt         <= '0;
      inpdt_R_reg <= '0;
      bias_buffer <= '0;
    end else begin
      if (state == IDLE && start) begin
        acc         <= '0;
        cnt         <= '0;
        bias_buffer <= bias_in;
      end else if (accept) begin
        acc <= acc_next;
        cnt <= cnt + CNT_W'(1);
        if (last) inpdt_R_reg <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_b_inpdt_mac.sv
// Scoreboard bench for b_inpdt_mac: expected inner product and bias are queued at start,
// popped and compared when the result is presented.
module tb_b_inpdt_mac;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, out_ready;
  logic [7:0]  bias_in, data_in, w_in;
  logic        in_ready, out_valid, busy;
  logic [31:0] inpdt_R_reg;
  logic [7:0]  bias_buffer;
  logic [4:0]  comb_ctrl;

  int          checks = 0;
  int          errors = 0;
  logic [39:0] sb[$];
  logic [7:0]  dv[16];
  logic [7:0]  wv[16];

  b_inpdt_mac dut (
    .clk(clk), .rst(rst), .start(start), .bias_in(bias_in),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in), .w_in(w_in),
    .out_valid(out_valid), .out_ready(out_ready), .inpdt_R_reg(inpdt_R_reg),
    .bias_buffer(bias_buffer), .comb_ctrl(comb_ctrl), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int d, input int w);
    for (int k = 0; k < 16; k++) begin
      dv[k] = 8'(d);
      wv[k] = 8'(w);
    end
  endtask

  // Drive one 16-element vector, then hold the result for 'hold' cycles before consuming it.
  // start_at >= 0 pulses a spurious start (bias 77) while that element is offered.
  task automatic run_vector(input logic [7:0] bias, input bit gaps, input int hold, input int start_at);
    int          sum = 0;
    int          i = 0;
    int          budget = 0;
    bit          take;
    logic [39:0] e;
    for (int k = 0; k < 16; k++) sum += (int'(dv[k]) - 128) * (int'(wv[k]) - 128);
    sb.push_back({sum[31:0], bias});
    bias_in = bias;
    start   = 1'b1;
    tick;
    start = 1'b0;
    check("busy_acc", 32'(busy), 32'd1);
    check("in_ready_acc", 32'(in_ready), 32'd1);
    while (i < 16 && budget < 200) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      data_in  = dv[i];
      w_in     = wv[i];
      start    = (i == start_at) ? 1'b1 : 1'b0;
      bias_in  = start ? 8'd77 : bias;
      take     = in_valid && in_ready;
      tick;
      if (take) i++;
      budget++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    check("accepted_count", i, 32'd16);
    check("latency_out_valid", 32'(out_valid), 32'd1);
    check("in_ready_done", 32'(in_ready), 32'd0);
    e = sb.pop_front();
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start     = (h == 1) ? 1'b1 : 1'b0;
      bias_in   = 8'd99;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_result", inpdt_R_reg, e[39:8]);
      check("hold_bias", 32'(bias_buffer), 32'(e[7:0]));
      check("hold_ctrl", 32'(comb_ctrl), 32'd5);
      tick;
    end
    // consume, with a start in the handshake cycle that must be dropped
    out_ready = 1'b1;
    start     = 1'b1;
    bias_in   = 8'd99;
    check("result", inpdt_R_reg, e[39:8]);
    check("bias", 32'(bias_buffer), 32'(e[7:0]));
    check("ctrl", 32'(comb_ctrl), 32'd5);
    check("out_valid", 32'(out_valid), 32'd1);
    tick;
    start     = 1'b0;
    out_ready = 1'b0;
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_ctrl", 32'(comb_ctrl), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_result_kept", inpdt_R_reg, e[39:8]);
    check("idle_bias_kept", 32'(bias_buffer), 32'(e[7:0]));
    tick;
    check("no_queued_start", 32'(busy), 32'd0);
    check("single_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_result"}, inpdt_R_reg, 32'd0);
    check({tag, "_bias"}, 32'(bias_buffer), 32'd0);
    check({tag, "_ctrl"}, 32'(comb_ctrl), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    bias_in = 8'd0; data_in = 8'd0; w_in = 8'd0;
    tick;
    tick;
    check_zero("reset");
    rst = 1'b0;
    tick;

    // in_valid during IDLE must not start anything
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    check("idle_ignores_valid", 32'(busy), 32'd0);

    fill(129, 130);
    run_vector(8'd200, 1'b0, 0, -1);          // 32
    fill(0, 255);
    run_vector(8'd13, 1'b0, 0, -1);           // -260096
    for (int k = 0; k < 16; k++) begin
      dv[k] = (k % 2 == 0) ? 8'd255 : 8'd0;
      wv[k] = 8'd255;
    end
    run_vector(8'd42, 1'b0, 0, -1);           // -1016
    fill(129, 130);
    run_vector(8'd200, 1'b1, 5, -1);          // gaps + backpressure
    for (int k = 0; k < 16; k++) begin
      dv[k] = 8'($urandom_range(0, 255));
      wv[k] = 8'($urandom_range(0, 255));
    end
    run_vector(8'd150, 1'b1, 3, 5);           // spurious starts in ACC and DONE

    // abort after 7 of 16 elements
    fill(129, 130);
    bias_in = 8'd55;
    start   = 1'b1;
    tick;
    start    = 1'b0;
    in_valid = 1'b1;
    data_in  = 8'd129;
    w_in     = 8'd130;
    repeat (7) tick;
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check_zero("abort");
    tick;
    rst = 1'b0;
    tick;
    check("abort_no_valid", 32'(out_valid), 32'd0);
    for (int k = 0; k < 16; k++) begin
      dv[k] = 8'd128;
      wv[k] = 8'($urandom_range(0, 255));
    end
    run_vector(8'd11, 1'b0, 0, -1);           // 0

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
